// File: rtl/dcache_line_memory_pkg.sv
// Shared definitions for the data-cache line memory and its cache-side requester.
package dcache_mem_pkg;

    localparam int LINE_BITS        = 256;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int ADDR_BITS        = 32;
    localparam int COUNT_BITS       = 8;

    // Handshake levels shared with the cache controller.
    localparam logic ENABLE_ACTIVE = 1'b1;
    localparam logic ACK_ACTIVE    = 1'b1;
    localparam logic REQ_WRITE     = 1'b1;
    localparam logic REQ_READ      = 1'b0;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COOLDOWN
    } state_e;

endpackage

// File: rtl/dcache_line_memory_if.sv
// Line request bus between the data cache (master) and the line memory (slave).
interface dcache_line_memory_if;
    import dcache_mem_pkg::*;

    logic                 enable;
    logic                 write;
    logic [ADDR_BITS-1:0] addr;
    line_t                wdata;
    logic                 ack;
    line_t                rdata;

    modport master (
        output enable, write, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  enable, write, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/dcache_line_memory_mem_line_array.sv
// Line storage: synchronous write, asynchronous read, one shared line index.
module mem_line_array
    import dcache_mem_pkg::*;
#(
    parameter  int DEPTH_LINES = 512,
    localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] index_i,
    input  line_t            data_i,
    output line_t            line_o
);

    line_t mem_q [DEPTH_LINES];

    // Commit a full line on the write strobe.
    // NOTE: the array has no reset so it maps onto RAM; its contents are undefined until written or preloaded.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[index_i] <= data_i;
        end
    end

    assign line_o = mem_q[index_i];

endmodule

// File: rtl/dcache_line_memory.sv
// Fixed-latency line memory serving data-cache refills and write-backs.
module dcache_line_memory
    import dcache_mem_pkg::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 512
) (
    input logic                 clk_i,
    input logic                 rst_i,
    dcache_line_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [COUNT_BITS-1:0] COUNT_LOAD = COUNT_BITS'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  write_q, write_d;
    line_t                 wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    line_t                 rdata_q, rdata_d;

    logic                  mem_we;
    line_t                 mem_line;
    logic [IDX_W-1:0]      req_index;
    logic                  unused_addr_bits;

    // Offset bits and bits above the index are dropped, so addresses wrap modulo DEPTH_LINES.
    assign req_index        = bus.addr[LINE_OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^{bus.addr[ADDR_BITS-1:LINE_OFFSET_BITS+IDX_W],
                                bus.addr[LINE_OFFSET_BITS-1:0]};

    // Next-state logic: accept in IDLE, count down in BUSY, absorb stale enable in COOLDOWN.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ~ACK_ACTIVE;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable == ENABLE_ACTIVE) begin
                    index_d = req_index;
                    write_d = bus.write;
                    wdata_d = bus.wdata;
                    count_d = COUNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Writes commit here, so a following read of the same line sees the new data.
                    if (write_q == REQ_WRITE) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_line;
                    end
                    ack_d   = ACK_ACTIVE;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                // The cache holds enable one cycle past ack; ignore it here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched request and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    mem_line_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .index_i (index_q),
        .data_i  (wdata_q),
        .line_o  (mem_line)
    );

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dcache_line_memory.sv
// Directed bench for dcache_line_memory: one instance at LATENCY=10, one at LATENCY=1.
module tb_dcache_line_memory;
    import dcache_mem_pkg::*;

    localparam int LAT   = 10;
    localparam int BOUND = 300;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    dcache_line_memory_if bus10 ();
    dcache_line_memory_if bus1 ();

    dcache_line_memory #(.LATENCY(LAT), .DEPTH_LINES(512)) dut10 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus10)
    );

    dcache_line_memory #(.LATENCY(1), .DEPTH_LINES(512)) dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus1)
    );

    int total = 0;
    int bad   = 0;

    line_t pat_a = {8{32'hAAAA_0003}};
    line_t pat_b = {8{32'hBBBB_0400}};
    line_t pat_c = {8{32'hCCCC_0001}};
    line_t pat_d = {8{32'hDDDD_0040}};
    line_t pat_o = {8{32'h0123_4567}};
    line_t pat_e = {8{32'hEEEE_0080}};
    line_t pat_f = {8{32'hFFFF_00A0}};
    line_t pat_g = {8{32'h5A5A_0020}};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a request on the LATENCY=10 instance; edges counts from the acceptance edge (k=0).
    task automatic req10(input logic wr, input logic [31:0] addr, input line_t wdata,
                         output int edges, output line_t rdata);
        bus10.enable = 1'b1;
        bus10.write  = wr;
        bus10.addr   = addr;
        bus10.wdata  = wdata;
        edges = -1;
        rdata = '0;
        for (int k = 0; k < BOUND; k++) begin
            tick();
            if (bus10.ack === 1'b1) begin
                edges = k;
                rdata = bus10.rdata;
                break;
            end
        end
    endtask

    task automatic release10();
        bus10.enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus10.enable = 1'b0; bus10.write = 1'b0; bus10.addr = '0; bus10.wdata = '0;
        bus1.enable  = 1'b0; bus1.write  = 1'b0; bus1.addr  = '0; bus1.wdata  = '0;
        #2;
        rst_i = 1'b0;
        tick();
        tick();
        total++;
        if (bus10.ack !== 1'b0) begin
            bad++; $display("FAIL reset_ack10: got %b want 0", bus10.ack);
        end
        total++;
        if (bus10.rdata !== '0) begin
            bad++; $display("FAIL reset_data10: got %h want 0", bus10.rdata);
        end
        total++;
        if (bus1.ack !== 1'b0) begin
            bad++; $display("FAIL reset_ack1: got %b want 0", bus1.ack);
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_read_latency();
        int    edges;
        line_t rd;
        req10(REQ_WRITE, 32'h0000_0060, pat_a, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL preload_write_latency: got %0d want %0d", edges, LAT);
        end
        release10();
        req10(REQ_READ, 32'h0000_0060, '0, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL read_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (rd !== pat_a) begin
            bad++; $display("FAIL read_data: got %h want %h", rd, pat_a);
        end
        release10();
        total++;
        if (bus10.ack !== 1'b0) begin
            bad++; $display("FAIL ack_single_cycle: got %b want 0", bus10.ack);
        end
        total++;
        if (bus10.rdata !== pat_a) begin
            bad++; $display("FAIL data_hold: got %h want %h", bus10.rdata, pat_a);
        end
    endtask

    task automatic test_write_then_read();
        int    edges;
        line_t rd;
        req10(REQ_WRITE, 32'h0000_0400, pat_b, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL write_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (rd !== pat_a) begin
            bad++; $display("FAIL write_keeps_data_o: got %h want %h", rd, pat_a);
        end
        // Enable stays high through COOLDOWN; it must not start a request.
        tick();
        total++;
        if (bus10.ack !== 1'b0) begin
            bad++; $display("FAIL stale_enable_ack: got %b want 0", bus10.ack);
        end
        req10(REQ_READ, 32'h0000_0400, '0, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL raw_read_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (rd !== pat_b) begin
            bad++; $display("FAIL raw_read_data: got %h want %h", rd, pat_b);
        end
        release10();
    endtask

    task automatic test_writeback_refill();
        int    edges;
        line_t rd;
        req10(REQ_WRITE, 32'h0000_00A0, pat_f, edges, rd);
        release10();
        req10(REQ_WRITE, 32'h0000_0080, pat_e, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL wb_latency: got %0d want %0d", edges, LAT);
        end
        tick();
        // Refill is accepted at the edge after COOLDOWN (ack edge + 2).
        req10(REQ_READ, 32'h0000_00A0, '0, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL refill_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (rd !== pat_f) begin
            bad++; $display("FAIL refill_data: got %h want %h", rd, pat_f);
        end
        release10();
        req10(REQ_READ, 32'h0000_0080, '0, edges, rd);
        total++;
        if (rd !== pat_e) begin
            bad++; $display("FAIL wb_line4_data: got %h want %h", rd, pat_e);
        end
        release10();
    endtask

    task automatic test_wrap_offset();
        int    edges;
        line_t rd;
        req10(REQ_WRITE, 32'h4000_0020, pat_c, edges, rd);
        release10();
        req10(REQ_READ, 32'h0000_003F, '0, edges, rd);
        total++;
        if (rd !== pat_c) begin
            bad++; $display("FAIL wrap_offset_data: got %h want %h", rd, pat_c);
        end
        release10();
        req10(REQ_READ, 32'h0000_4020, '0, edges, rd);
        total++;
        if (rd !== pat_c) begin
            bad++; $display("FAIL wrap_high_bit_data: got %h want %h", rd, pat_c);
        end
        release10();
    endtask

    task automatic test_reset_mid_request();
        int    edges;
        line_t rd;
        int    acks;
        req10(REQ_WRITE, 32'h0000_0040, pat_o, edges, rd);
        release10();
        bus10.enable = 1'b1;
        bus10.write  = REQ_WRITE;
        bus10.addr   = 32'h0000_0040;
        bus10.wdata  = pat_d;
        // Acceptance edge plus four more leaves the counter at 5.
        for (int k = 0; k < 5; k++) tick();
        rst_i = 1'b0;
        bus10.enable = 1'b0;
        acks = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (bus10.ack !== 1'b0) acks++;
        end
        rst_i = 1'b1;
        total++;
        if (bus10.rdata !== '0) begin
            bad++; $display("FAIL mid_reset_data_o: got %h want 0", bus10.rdata);
        end
        for (int k = 0; k < 14; k++) begin
            tick();
            if (bus10.ack !== 1'b0) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL mid_reset_no_ack: got %0d acks want 0", acks);
        end
        req10(REQ_READ, 32'h0000_0040, '0, edges, rd);
        total++;
        if (edges !== LAT) begin
            bad++; $display("FAIL post_reset_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (rd !== pat_o) begin
            bad++; $display("FAIL mid_reset_old_line: got %h want %h", rd, pat_o);
        end
        release10();
    endtask

    task automatic test_back_to_back_lat1();
        int  edges;
        logic want_ack;
        bus1.enable = 1'b1;
        bus1.write  = REQ_WRITE;
        bus1.addr   = 32'h0000_0020;
        bus1.wdata  = pat_g;
        edges = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus1.ack === 1'b1) begin
                edges = k;
                break;
            end
        end
        total++;
        if (edges !== 1) begin
            bad++; $display("FAIL lat1_write_latency: got %0d want 1", edges);
        end
        // Enable stays high; reads should ack every third edge after the write ack.
        bus1.write = REQ_READ;
        for (int k = 1; k <= 12; k++) begin
            tick();
            want_ack = ((k % 3) == 0);
            total++;
            if (bus1.ack !== want_ack) begin
                bad++; $display("FAIL lat1_ack_k%0d: got %b want %b", k, bus1.ack, want_ack);
            end
            if (want_ack) begin
                total++;
                if (bus1.rdata !== pat_g) begin
                    bad++; $display("FAIL lat1_data_k%0d: got %h want %h", k, bus1.rdata, pat_g);
                end
            end
        end
        bus1.enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_writeback_refill();
        test_wrap_offset();
        test_reset_mid_request();
        test_back_to_back_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
